// File: rtl/mem_wb_stage_buf.sv
// mem_wb_stage_buf: MEM->WB pipeline stage with valid/ready handshake, 2-entry skid buffer, flush and retire counter
module mem_wb_stage_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [DATA_W-1:0] MUX3_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              WB_o_1,
  output logic              WB_o_2,
  output logic [DATA_W-1:0] ReadData_o,
  output logic [DATA_W-1:0] MUX3_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);
  localparam int P_W = 2 + 2 * DATA_W + ADDR_W;
  logic           h_v, s_v, accept, drain;
  logic [P_W-1:0] h_p, s_p, in_p;
  logic [1:0]     h_wb;
  assign in_p        = {WB_i, ReadData_i, MUX3_i, addr_i};
  assign in_ready_o  = !s_v;
  assign out_valid_o = h_v;
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = h_v & out_ready_i;
  assign {h_wb, ReadData_o, MUX3_o, addr_o} = h_p;
  assign WB_o_1      = h_v & h_wb[1];
  assign WB_o_2      = h_v & h_wb[0];
  assign wb_data_o   = WB_o_2 ? ReadData_o : MUX3_o;
  // Payload registers only load on capture so a bubble keeps the last head payload visible.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_v          <= 1'b0;
      s_v          <= 1'b0;
      h_p          <= '0;
      s_p          <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (drain && h_wb[1]) retire_cnt_o <= retire_cnt_o + 1'b1;
      if (flush_i) begin
        h_v <= 1'b0;
        s_v <= 1'b0;
      end else if (drain && s_v) begin
        h_p <= s_p;
        s_v <= accept;
        if (accept) s_p <= in_p;
      end else if (drain || !h_v) begin
        h_v <= accept;
        if (accept) h_p <= in_p;
      end else if (accept) begin
        s_v <= 1'b1;
        s_p <= in_p;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// tb_mem_wb_stage_buf: randomized and directed checks of mem_wb_stage_buf against a queue-based model
module tb_mem_wb_stage_buf;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] m3;
    logic [4:0]  ad;
  } entry_t;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [1:0] wb_in = 0;
  logic [31:0] rd_in = 0, m3_in = 0;
  logic [4:0] ad_in = 0;
  logic in_ready, out_valid, wb1, wb2;
  logic [31:0] rd_out, m3_out, wb_data;
  logic [4:0] ad_out;
  logic [CNT_W-1:0] cnt_out;
  entry_t q[$];
  entry_t last;
  int cnt, tests, fails;
  mem_wb_stage_buf #(.DATA_W(32), .ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .WB_i(wb_in), .ReadData_i(rd_in), .MUX3_i(m3_in), .addr_i(ad_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .WB_o_1(wb1), .WB_o_2(wb2),
    .ReadData_o(rd_out), .MUX3_o(m3_out), .addr_o(ad_out), .wb_data_o(wb_data),
    .retire_cnt_o(cnt_out)
  );
  always #5 clk = ~clk;
  function automatic entry_t mk(input logic [1:0] w, input logic [31:0] r, input logic [31:0] m, input logic [4:0] a);
    entry_t e;
    e.wb = w; e.rd = r; e.m3 = m; e.ad = a;
    return e;
  endfunction
  function automatic entry_t rnd();
    return mk(2'($urandom), $urandom, $urandom, 5'($urandom));
  endfunction
  function automatic logic [108:0] act_vec();
    return {out_valid, in_ready, wb1, wb2, rd_out, m3_out, ad_out, wb_data, cnt_out};
  endfunction
  function automatic logic [108:0] exp_vec();
    logic ov, w1, w2;
    ov = q.size() > 0;
    w1 = ov & last.wb[1];
    w2 = ov & last.wb[0];
    return {ov, q.size() < 2, w1, w2, last.rd, last.m3, last.ad, w2 ? last.rd : last.m3, CNT_W'(cnt)};
  endfunction
  task automatic tick(input logic v, input entry_t e, input logic ordy, input logic fl);
    logic dr, ac;
    in_valid = v; {wb_in, rd_in, m3_in, ad_in} = e; out_ready = ordy; flush = fl;
    @(posedge clk);
    if (rst) begin
      q.delete(); last = '0; cnt = 0;
    end else begin
      dr = q.size() > 0 && ordy;
      ac = v && q.size() < 2;
      if (dr && q[0].wb[1]) cnt = (cnt + 1) % (1 << CNT_W);
      if (fl) q.delete();
      else begin
        if (dr) void'(q.pop_front());
        if (ac) q.push_back(e);
      end
      if (q.size() > 0) last = q[0];
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    tick(1, rnd(), 1'($urandom), 1'($urandom));
    tick(1, rnd(), 1'($urandom), 1'($urandom));
    rst = 0;
    tests++;
    if (act_vec() !== {1'b0, 1'b1, 107'd0}) begin
      fails++; $display("FAIL reset: got %h want %h", act_vec(), {1'b0, 1'b1, 107'd0});
    end
    tests++;
    if (act_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_model: got %h want %h", act_vec(), exp_vec());
    end
  endtask
  task automatic test_pass_through();
    tick(1, mk(2'b11, 32'hDEADBEEF, 32'h10, 5'd7), 1, 0);
    tests++;
    if ({out_valid, wb1, wb_data, ad_out} !== {1'b1, 1'b1, 32'hDEADBEEF, 5'd7}) begin
      fails++; $display("FAIL pass_through: got v=%b w1=%b d=%h a=%0d want v=1 w1=1 d=deadbeef a=7", out_valid, wb1, wb_data, ad_out);
    end
    tick(0, rnd(), 1, 0);
    tests++;
    if (cnt_out !== CNT_W'(1) || out_valid !== 1'b0) begin
      fails++; $display("FAIL pass_cnt: got cnt=%0d v=%b want cnt=1 v=0", cnt_out, out_valid);
    end
  endtask
  task automatic test_backpressure();
    tick(1, mk(2'b10, 0, 32'h1, 1), 0, 0);
    tick(1, mk(2'b10, 0, 32'h2, 2), 0, 0);
    tests++;
    if (in_ready !== 1'b0 || m3_out !== 32'h1) begin
      fails++; $display("FAIL bp_full: got rdy=%b head=%h want rdy=0 head=1", in_ready, m3_out);
    end
    tick(1, mk(2'b10, 0, 32'h3, 3), 0, 0);
    tick(1, mk(2'b10, 0, 32'h3, 3), 1, 0);
    tests++;
    if (m3_out !== 32'h2 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_order_b: got %h v=%b want 2 v=1", m3_out, out_valid);
    end
    tick(1, mk(2'b10, 0, 32'h3, 3), 1, 0);
    tests++;
    if (m3_out !== 32'h3 || out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_order_c: got %h v=%b want 3 v=1", m3_out, out_valid);
    end
    tick(0, rnd(), 1, 0);
    tests++;
    if (act_vec() !== exp_vec() || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_drained: got %h want %h", act_vec(), exp_vec());
    end
  endtask
  task automatic test_flush();
    tick(1, mk(2'b10, 0, 32'hA, 1), 0, 0);
    tick(1, mk(2'b10, 0, 32'hB, 2), 0, 0);
    tick(1, mk(2'b10, 0, 32'hD, 4), 0, 1);
    tests++;
    if ({out_valid, wb1, in_ready} !== 3'b001) begin
      fails++; $display("FAIL flush: got v=%b w1=%b rdy=%b want v=0 w1=0 rdy=1", out_valid, wb1, in_ready);
    end
    tick(0, rnd(), 1, 0);
    tests++;
    if (out_valid !== 1'b0 || m3_out === 32'hD) begin
      fails++; $display("FAIL flush_no_d: got v=%b head=%h want v=0 head!=d", out_valid, m3_out);
    end
  endtask
  task automatic test_bubble();
    tick(1, mk(2'b10, 32'hAA, 32'h55, 9), 0, 0);
    tests++;
    if ({wb1, wb2, wb_data} !== {2'b10, 32'h55}) begin
      fails++; $display("FAIL memtoreg: got w1=%b w2=%b d=%h want w1=1 w2=0 d=55", wb1, wb2, wb_data);
    end
    tick(0, rnd(), 1, 0);
    tests++;
    if ({out_valid, wb1, wb2, m3_out} !== {3'b000, 32'h55}) begin
      fails++; $display("FAIL bubble: got v=%b w1=%b w2=%b m3=%h want 0 0 0 55", out_valid, wb1, wb2, m3_out);
    end
  endtask
  task automatic test_counter_wrap();
    rst = 1; tick(0, rnd(), 0, 0); rst = 0;
    for (int i = 0; i < 16; i++) tick(1, mk({1'b1, 1'($urandom)}, $urandom, $urandom, 5'($urandom)), 1, 0);
    tick(0, rnd(), 1, 0);
    tests++;
    if (cnt_out !== CNT_W'(0)) begin
      fails++; $display("FAIL cnt_wrap: got %0d want 0", cnt_out);
    end
    tick(1, mk(2'b01, $urandom, $urandom, 3), 1, 0);
    tick(0, rnd(), 1, 0);
    tests++;
    if (cnt_out !== CNT_W'(0) || cnt != 0) begin
      fails++; $display("FAIL cnt_noinc: got %0d want 0", cnt_out);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 2) != 0), $urandom_range(0, 19) == 0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask
  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_flush();
    test_bubble();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
